// File: rtl/result_capture_pkg.sv
// result_capture shared definitions:
// default parameters and hex to 7-segment decode.
package result_capture_pkg;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 4;
  localparam int DEF_DEPTH         = 8;

  // bit0=a .. bit6=g, active-high
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex_to_seg(
    input logic [3:0] v
  );
    return SEG_LUT[v];
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for signals
// arriving asynchronously to clk.
module sync_ff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stg [STAGES];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++)
        stg[i] <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < STAGES; i++)
        stg[i] <= stg[i-1];
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/result_capture.sv
// Captures settled results from the async
// processing block into a FIFO shown on 7-seg.
module result_capture
  import result_capture_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int DEPTH         = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [3:0]               res_in,
  input  logic                     pop_btn,
  input  logic                     clear,
  output logic [6:0]               seg_out,
  output logic                     dp,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [SW-1:0] CNT_MAX = SW'(STABLE_CYCLES - 1);
  localparam logic [SW-1:0] CNT_ACC = SW'(STABLE_CYCLES - 2);

  logic [3:0]    res_s;
  logic          pop_s;
  logic          pop_prev;
  logic [3:0]    cand;
  logic [SW-1:0] stab;
  logic [3:0]    last;
  logic          accept;
  logic          push_req;
  logic          pop_req;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          do_pop;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [3:0]    mem [DEPTH];

  sync_ff #(
    .WIDTH  (4),
    .STAGES (SYNC_STAGES)
  ) u_res_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (res_in),
    .q     (res_s)
  );

  sync_ff #(
    .WIDTH  (1),
    .STAGES (SYNC_STAGES)
  ) u_pop_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pop_btn),
    .q     (pop_s)
  );

  always_comb begin
    accept   = (res_s == cand) && (stab == CNT_ACC);
    push_req = accept && (cand != last);
    pop_req  = pop_s & ~pop_prev;
    full     = (count == FULL_CNT);
    empty    = (count == '0);
    do_pop   = pop_req && !empty;
    do_push  = push_req && (!full || do_pop);
  end

  // Stability filter and edge detect
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand     <= '0;
      stab     <= '0;
      last     <= '0;
      pop_prev <= 1'b0;
    end else begin
      pop_prev <= pop_s;
      if (res_s != cand) begin
        cand <= res_s;
        stab <= '0;
      end else if (stab != CNT_MAX) begin
        stab <= stab + SW'(1);
      end
      if (push_req)
        last <= cand;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push)
        wptr <= wptr + AW'(1);
      if (do_pop)
        rptr <= rptr + AW'(1);
      if (do_push && !do_pop)
        count <= count + CW'(1);
      else if (do_pop && !do_push)
        count <= count - CW'(1);
      if (push_req && full && !do_pop)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !clear && do_push)
      mem[wptr] <= cand;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || empty) begin
      seg_out <= '0;
      dp      <= 1'b0;
    end else begin
      seg_out <= hex_to_seg(mem[rptr]);
      dp      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_result_capture.sv
// Directed self-checking bench for
// result_capture with default parameters.
module tb_result_capture;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] res_in;
  logic       pop_btn;
  logic       clear;
  logic [6:0] seg_out;
  logic       dp;
  logic [3:0] count;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  result_capture dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .res_in   (res_in),
    .pop_btn  (pop_btn),
    .clear    (clear),
    .seg_out  (seg_out),
    .dp       (dp),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic log_val(input logic [3:0] v);
    res_in = v;
    tick(10);
  endtask

  task automatic press_pop(input int hold);
    pop_btn = 1'b1;
    tick(hold);
    pop_btn = 1'b0;
    tick(6);
  endtask

  task automatic pulse_clear;
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    res_in  = 4'h0;
    pop_btn = 1'b0;
    clear   = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(20);
    checks++;
    if (count !== 4'd0) begin
      errors++;
      $display("FAIL reset_count got %0d exp 0", count);
    end
    checks++;
    if (dp !== 1'b0) begin
      errors++;
      $display("FAIL reset_dp got %b exp 0", dp);
    end
    checks++;
    if (seg_out !== 7'h00) begin
      errors++;
      $display("FAIL reset_seg got %h exp 00", seg_out);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf got %b exp 0", overflow);
    end
  endtask

  task automatic test_latency;
    res_in = 4'h5;
    tick(5);
    checks++;
    if (count !== 4'd0) begin
      errors++;
      $display("FAIL lat_early got %0d exp 0", count);
    end
    tick(1);
    checks++;
    if (count !== 4'd1) begin
      errors++;
      $display("FAIL lat_count got %0d exp 1", count);
    end
    checks++;
    if (dp !== 1'b0) begin
      errors++;
      $display("FAIL lat_dp_early got %b exp 0", dp);
    end
    tick(1);
    checks++;
    if (seg_out !== 7'h6D || dp !== 1'b1) begin
      errors++;
      $display("FAIL lat_seg got %h/%b exp 6d/1",
               seg_out, dp);
    end
    tick(10);
    res_in = 4'h5;
    tick(10);
    checks++;
    if (count !== 4'd1) begin
      errors++;
      $display("FAIL no_repeat got %0d exp 1", count);
    end
  endtask

  task automatic test_glitch;
    res_in = 4'h9;
    tick(2);
    res_in = 4'h5;
    tick(12);
    checks++;
    if (count !== 4'd1 || seg_out !== 7'h6D) begin
      errors++;
      $display("FAIL glitch got %0d/%h exp 1/6d",
               count, seg_out);
    end
  endtask

  task automatic test_log_pop;
    pulse_clear();
    checks++;
    if (count !== 4'd0 || dp !== 1'b1) begin
      errors++;
      $display("FAIL clr_edge got %0d/%b exp 0/1",
               count, dp);
    end
    tick(1);
    checks++;
    if (seg_out !== 7'h00 || dp !== 1'b0) begin
      errors++;
      $display("FAIL clr_disp got %h/%b exp 00/0",
               seg_out, dp);
    end
    log_val(4'h3);
    log_val(4'hA);
    log_val(4'h7);
    checks++;
    if (count !== 4'd3 || seg_out !== 7'h4F) begin
      errors++;
      $display("FAIL log3 got %0d/%h exp 3/4f",
               count, seg_out);
    end
    pop_btn = 1'b1;
    tick(2);
    checks++;
    if (count !== 4'd3) begin
      errors++;
      $display("FAIL pop_early got %0d exp 3", count);
    end
    tick(1);
    checks++;
    if (count !== 4'd2 || seg_out !== 7'h4F) begin
      errors++;
      $display("FAIL pop_edge got %0d/%h exp 2/4f",
               count, seg_out);
    end
    tick(1);
    checks++;
    if (seg_out !== 7'h77) begin
      errors++;
      $display("FAIL pop1_seg got %h exp 77", seg_out);
    end
    pop_btn = 1'b0;
    tick(4);
    press_pop(1);
    checks++;
    if (count !== 4'd1 || seg_out !== 7'h07) begin
      errors++;
      $display("FAIL pop2 got %0d/%h exp 1/07",
               count, seg_out);
    end
    press_pop(1);
    checks++;
    if (count !== 4'd0 || seg_out !== 7'h00 ||
        dp !== 1'b0) begin
      errors++;
      $display("FAIL pop3 got %0d/%h/%b exp 0/00/0",
               count, seg_out, dp);
    end
    press_pop(1);
    checks++;
    if (count !== 4'd0 || seg_out !== 7'h00 ||
        overflow !== 1'b0) begin
      errors++;
      $display("FAIL pop_empty got %0d/%h exp 0/00",
               count, seg_out);
    end
    log_val(4'h1);
    log_val(4'h8);
    press_pop(20);
    checks++;
    if (count !== 4'd1 || seg_out !== 7'h7F) begin
      errors++;
      $display("FAIL pop_held got %0d/%h exp 1/7f",
               count, seg_out);
    end
  endtask

  task automatic test_overflow;
    pulse_clear();
    tick(1);
    for (int i = 0; i < 8; i++)
      log_val(4'(i));
    checks++;
    if (count !== 4'd8 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL fill8 got %0d/%b exp 8/0",
               count, overflow);
    end
    log_val(4'h9);
    checks++;
    if (count !== 4'd8 || overflow !== 1'b1 ||
        seg_out !== 7'h3F) begin
      errors++;
      $display("FAIL ovf got %0d/%b/%h exp 8/1/3f",
               count, overflow, seg_out);
    end
    pulse_clear();
    checks++;
    if (count !== 4'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr got %0d/%b exp 0/0",
               count, overflow);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] fill [8];
    logic [6:0] heads [7];
    fill  = '{4'hA, 4'hB, 4'hC, 4'hD,
              4'hE, 4'hF, 4'h1, 4'h2};
    heads = '{7'h39, 7'h5E, 7'h79, 7'h71,
              7'h06, 7'h5B, 7'h4F};
    tick(1);
    for (int i = 0; i < 8; i++)
      log_val(fill[i]);
    res_in = 4'h3;
    tick(3);
    pop_btn = 1'b1;
    tick(3);
    checks++;
    if (count !== 4'd8 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b got %0d/%b exp 8/0",
               count, overflow);
    end
    pop_btn = 1'b0;
    tick(5);
    checks++;
    if (seg_out !== 7'h7C) begin
      errors++;
      $display("FAIL b2b_head got %h exp 7c", seg_out);
    end
    for (int i = 0; i < 7; i++) begin
      press_pop(1);
      checks++;
      if (seg_out !== heads[i] ||
          count !== 4'(7 - i)) begin
        errors++;
        $display("FAIL drain%0d got %h/%0d exp %h/%0d",
                 i, seg_out, count, heads[i], 7 - i);
      end
    end
    rst_n = 1'b0;
    tick(1);
    checks++;
    if (count !== 4'd0 || seg_out !== 7'h00 ||
        dp !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst got %0d/%h/%b/%b exp 0",
               count, seg_out, dp, overflow);
    end
    rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_log_pop();
    test_overflow();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
